mem_stage: RTL and testbench
============================

# mem_stage

Parametrised MIPS memory stage: data memory plus the MEM/WB pipeline register. It supports byte, halfword and word accesses with optional sign extension and misaligned-address detection. A configurable number of wait states stalls the pipeline through the hazard unit. It sits between the execute-stage EX/MEM register and the writeback mux, and replaces the single-cycle, word-only, unregistered memory stage.

## Interface
- DEPTH_WORDS, 1024: data memory size in 32-bit words; power of two; index bits AW = log2(DEPTH_WORDS).
- WAIT_STATES, 0: extra cycles per load/store, 0..7.
- clk  in  1  rising-edge clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- RegWriteM  in  1  instruction writes register file.
- MemToRegM  in  1  writeback selects memory data.
- MemReadM  in  1  load.
- MemWriteM  in  1  store; wins if MemReadM is also high.
- MemSizeM  in  2  00 byte, 01 half, 10/11 word.
- MemSignedM  in  1  sign-extend byte/half loads (else zero-extend).
- ALUOutM  in  32  byte address / ALU result.
- WriteDataM  in  32  store data; right-justified for byte/half.
- WriteRegM  in  5  destination register.
- StallM  out  1  freeze F/D/E/M stages; combinational.
- RegWriteW  out  1  registered.
- MemToRegW  out  1  registered.
- ReadDataW  out  32  registered, extended load data.
- ALUOutW  out  32  registered copy of ALUOutM.
- WriteRegW  out  5  registered copy of WriteRegM (also fed to hazard unit).
- AddrErrW  out  1  registered; misaligned access flag.

## Operation
- Access = MemReadM | MemWriteM. Word index = ALUOutM[AW+1:2]; higher address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- Byte lanes are little-endian: lane k = bits 8k+7:8k, selected by ALUOutM[1:0]. Half lane is ALUOutM[1].
- Byte store writes only the selected lane with WriteDataM[7:0]. Half store writes two lanes with WriteDataM[15:0]. Word store writes all lanes. Other bytes are untouched.
- Load returns the selected byte/half, extended to 32 bits per MemSignedM; a word load ignores MemSignedM.
- Misaligned access is a half with ALUOutM[0]=1, or a word with ALUOutM[1:0]!=0. It performs no write and takes no wait states. Result: AddrErrW=1, RegWriteW=0, MemToRegW=0, ReadDataW=0 for one W cycle.
- The FSM has two states:
  - IDLE to WAIT when an aligned access arrives and WAIT_STATES>0; counter cnt loads 1.
  - WAIT increments cnt each cycle and returns to IDLE on the cycle where cnt==WAIT_STATES.
  - Access cycle k runs 0..WAIT_STATES; k=0 is the IDLE cycle.
- StallM = aligned access && k < WAIT_STATES. Upstream holds all *M inputs stable while StallM=1; a change during stall is undefined.
- While StallM=1, the MEM/WB register loads a bubble (RegWriteW=0, MemToRegW=0, AddrErrW=0); other W fields are don't-care.
- Non-memory instructions pass through in one cycle with StallM=0.
- Memory contents are not reset (initialised to 0 in simulation only).

## Timing
- Reset: all W outputs 0, StallM 0, FSM IDLE, cnt 0.
- Reset during WAIT abandons the access: no store is committed and the next cycle is IDLE.
- Store commits at the rising edge ending cycle k=WAIT_STATES.
- Load reads synchronously at that same edge; ReadDataW is valid the following cycle, with the other W fields.
- Latency: M inputs to W outputs = WAIT_STATES+1 cycles for memory ops and 1 cycle otherwise.
- Throughput: one access per WAIT_STATES+1 cycles; back-to-back accesses re-enter WAIT immediately with no idle gap.
- Store followed by a load to the same word on the next access: the load returns the new data (write-first; no bypass needed since accesses are serial).
- Misaligned inputs never assert StallM.

## Test plan
- WAIT_STATES=0: word store 0xDEADBEEF @0x10, then word load @0x10 -> next cycle ReadDataW=0xDEADBEEF, MemToRegW=1, StallM never high.
- Byte store 0x80 @0x13, then load byte signed @0x13 -> 0xFFFFFF80; unsigned -> 0x00000080. Word load @0x10 -> 0x80ADBEEF.
- Half store 0x1234 @0x16 over word 0 -> word @0x14 = 0x12340000; half load @0x16 signed -> 0x00001234.
- Word load @0x02, and half load @0x01 -> AddrErrW=1, RegWriteW=0, memory unchanged, StallM=0.
- WAIT_STATES=3: store then load -> StallM high exactly 3 cycles each with W bubbles; ReadDataW valid on cycle 4 after load issue.
- WAIT_STATES=3: assert reset at k=2 of a store -> all outputs 0 next cycle; later load of that address returns the old value.
- Address 0x1000+0x10 with DEPTH_WORDS=1024 aliases to 0x10 (wrap check).

Source files
------------

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
// MIPS memory stage: byte/half/word data memory with optional sign
// extension, misaligned-address detection, configurable wait states and
// the MEM/WB pipeline register.
//
// Parameters
//   DEPTH_WORDS  data memory size in 32-bit words (power of two)
//   WAIT_STATES  extra cycles per aligned load/store, 0..7
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   RegWriteM ..      execute-stage (EX/MEM) control and data inputs
//   StallM            combinational; freezes F/D/E/M while an access waits
//   *W outputs        registered MEM/WB fields; AddrErrW flags misalignment
// ---------------------------------------------------------------------------
module mem_stage #(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_STATES = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        RegWriteM,
   input  logic        MemToRegM,
   input  logic        MemReadM,
   input  logic        MemWriteM,
   input  logic [1:0]  MemSizeM,
   input  logic        MemSignedM,
   input  logic [31:0] ALUOutM,
   input  logic [31:0] WriteDataM,
   input  logic [4:0]  WriteRegM,
   output logic        StallM,
   output logic        RegWriteW,
   output logic        MemToRegW,
   output logic [31:0] ReadDataW,
   output logic [31:0] ALUOutW,
   output logic [4:0]  WriteRegW,
   output logic        AddrErrW
);

   localparam int         AW = $clog2(DEPTH_WORDS);
   localparam logic [2:0] WS = 3'(WAIT_STATES);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   state_t        state_r;
   state_t        state_nxt_s;
   logic [2:0]    cnt_r;
   logic [2:0]    cnt_nxt_s;

   logic [31:0]   mem_r [DEPTH_WORDS];

   logic [AW-1:0] idx_s;
   logic [1:0]    off_s;
   logic          access_s;
   logic          misaligned_s;
   logic          aligned_acc_s;
   logic [2:0]    k_s;
   logic          stall_s;
   logic          commit_s;
   logic          we_s;
   logic          load_s;
   logic [3:0]    mask_s;
   logic [31:0]   wlanes_s;
   logic [31:0]   rd_word_s;
   logic [31:0]   rd_ext_s;

   // Byte lanes touched by an access of the given size at the given offset.
   function automatic logic [3:0] lane_mask(input logic [1:0] size,
                                            input logic [1:0] off);
      logic [3:0] m;
      case (size)
         2'b00:   m = 4'b0001 << off;
         2'b01:   m = off[1] ? 4'b1100 : 4'b0011;
         default: m = 4'b1111;
      endcase
      return m;
   endfunction

   // Replicate right-justified store data across all lanes so the lane
   // mask alone decides which bytes land in memory.
   function automatic logic [31:0] store_lanes(input logic [1:0]  size,
                                               input logic [31:0] data);
      logic [31:0] r;
      case (size)
         2'b00:   r = {4{data[7:0]}};
         2'b01:   r = {2{data[15:0]}};
         default: r = data;
      endcase
      return r;
   endfunction

   // Select the addressed byte/half of a word and sign- or zero-extend it.
   function automatic logic [31:0] extend_load(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  off,
                                               input logic        sgn);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = word[{off, 3'b000} +: 8];
      h = off[1] ? word[31:16] : word[15:0];
      case (size)
         2'b00:   r = {{24{sgn & b[7]}}, b};
         2'b01:   r = {{16{sgn & h[15]}}, h};
         default: r = word;
      endcase
      return r;
   endfunction

   assign idx_s    = ALUOutM[AW+1:2];
   assign off_s    = ALUOutM[1:0];
   assign access_s = MemReadM | MemWriteM;
   assign load_s   = MemReadM & ~MemWriteM;

   // Misalignment decode: byte never misaligned, half on odd address,
   // word on any non-zero offset.
   always_comb begin
      misaligned_s = 1'b0;
      case (MemSizeM)
         2'b00:   misaligned_s = 1'b0;
         2'b01:   misaligned_s = access_s & off_s[0];
         default: misaligned_s = access_s & (off_s != 2'b00);
      endcase
   end

   assign aligned_acc_s = access_s & ~misaligned_s;

   // k is the access cycle index; since k runs 0..WS, k<WS is k!=WS.
   assign k_s      = (state_r == ST_WAIT) ? cnt_r : 3'd0;
   assign stall_s  = aligned_acc_s & (k_s != WS);
   assign commit_s = aligned_acc_s & ~stall_s;
   assign we_s     = commit_s & MemWriteM & ~reset;
   assign StallM   = stall_s;

   assign mask_s    = lane_mask(MemSizeM, off_s);
   assign wlanes_s  = store_lanes(MemSizeM, WriteDataM);
   assign rd_word_s = mem_r[idx_s];
   assign rd_ext_s  = extend_load(rd_word_s, MemSizeM, off_s, MemSignedM);

   // Wait-state FSM next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      case (state_r)
         ST_IDLE: begin
            if (stall_s) begin
               state_nxt_s = ST_WAIT;
               cnt_nxt_s   = 3'd1;
            end else begin
               state_nxt_s = ST_IDLE;
               cnt_nxt_s   = 3'd0;
            end
         end
         ST_WAIT: begin
            if (cnt_r == WS) begin
               state_nxt_s = ST_IDLE;
               cnt_nxt_s   = 3'd0;
            end else begin
               state_nxt_s = ST_WAIT;
               cnt_nxt_s   = cnt_r + 3'd1;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = 3'd0;
         end
      endcase
   end

   // Wait-state FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
         cnt_r   <= 3'd0;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
      end
   end

   // Data memory write port; contents are deliberately not reset, and a
   // reset in the commit cycle suppresses the store.
   always_ff @(posedge clk) begin
      if (we_s) begin
         for (int l = 0; l < 4; l++) begin
            if (mask_s[l]) begin
               mem_r[idx_s][8*l +: 8] <= wlanes_s[8*l +: 8];
            end
         end
      end
   end

   // MEM/WB pipeline register: bubble while stalled, error record on a
   // misaligned access, normal result otherwise.
   always_ff @(posedge clk) begin
      if (reset) begin
         RegWriteW <= 1'b0;
         MemToRegW <= 1'b0;
         ReadDataW <= 32'd0;
         ALUOutW   <= 32'd0;
         WriteRegW <= 5'd0;
         AddrErrW  <= 1'b0;
      end else if (stall_s) begin
         RegWriteW <= 1'b0;
         MemToRegW <= 1'b0;
         ReadDataW <= 32'd0;
         ALUOutW   <= ALUOutM;
         WriteRegW <= WriteRegM;
         AddrErrW  <= 1'b0;
      end else if (misaligned_s) begin
         RegWriteW <= 1'b0;
         MemToRegW <= 1'b0;
         ReadDataW <= 32'd0;
         ALUOutW   <= ALUOutM;
         WriteRegW <= WriteRegM;
         AddrErrW  <= 1'b1;
      end else begin
         RegWriteW <= RegWriteM;
         MemToRegW <= MemToRegM;
         ReadDataW <= load_s ? rd_ext_s : 32'd0;
         ALUOutW   <= ALUOutM;
         WriteRegW <= WriteRegM;
         AddrErrW  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // DUT a: WAIT_STATES = 0
   logic        a_reset, a_regw, a_m2r, a_rd, a_wr, a_sgn;
   logic [1:0]  a_size;
   logic [31:0] a_addr, a_wdata;
   logic [4:0]  a_wreg;
   logic        a_stall, a_regw_w, a_m2r_w, a_aerr_w;
   logic [31:0] a_rdata_w, a_alu_w;
   logic [4:0]  a_wreg_w;

   // DUT b: WAIT_STATES = 3
   logic        b_reset, b_regw, b_m2r, b_rd, b_wr, b_sgn;
   logic [1:0]  b_size;
   logic [31:0] b_addr, b_wdata;
   logic [4:0]  b_wreg;
   logic        b_stall, b_regw_w, b_m2r_w, b_aerr_w;
   logic [31:0] b_rdata_w, b_alu_w;
   logic [4:0]  b_wreg_w;

   int checks = 0;
   int passed = 0;

   mem_stage #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u_a (
      .clk(clk), .reset(a_reset),
      .RegWriteM(a_regw), .MemToRegM(a_m2r), .MemReadM(a_rd), .MemWriteM(a_wr),
      .MemSizeM(a_size), .MemSignedM(a_sgn), .ALUOutM(a_addr),
      .WriteDataM(a_wdata), .WriteRegM(a_wreg),
      .StallM(a_stall), .RegWriteW(a_regw_w), .MemToRegW(a_m2r_w),
      .ReadDataW(a_rdata_w), .ALUOutW(a_alu_w), .WriteRegW(a_wreg_w),
      .AddrErrW(a_aerr_w)
   );

   mem_stage #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) u_b (
      .clk(clk), .reset(b_reset),
      .RegWriteM(b_regw), .MemToRegM(b_m2r), .MemReadM(b_rd), .MemWriteM(b_wr),
      .MemSizeM(b_size), .MemSignedM(b_sgn), .ALUOutM(b_addr),
      .WriteDataM(b_wdata), .WriteRegM(b_wreg),
      .StallM(b_stall), .RegWriteW(b_regw_w), .MemToRegW(b_m2r_w),
      .ReadDataW(b_rdata_w), .ALUOutW(b_alu_w), .WriteRegW(b_wreg_w),
      .AddrErrW(b_aerr_w)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic drive_a(input logic rd, input logic wr, input logic [1:0] size,
                          input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic regw, input logic m2r, input logic [4:0] wreg);
      a_rd = rd; a_wr = wr; a_size = size; a_sgn = sgn; a_addr = addr;
      a_wdata = wdata; a_regw = regw; a_m2r = m2r; a_wreg = wreg;
   endtask

   task automatic drive_b(input logic rd, input logic wr, input logic [1:0] size,
                          input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic regw, input logic m2r, input logic [4:0] wreg);
      b_rd = rd; b_wr = wr; b_size = size; b_sgn = sgn; b_addr = addr;
      b_wdata = wdata; b_regw = regw; b_m2r = m2r; b_wreg = wreg;
   endtask

   // One instruction on DUT a: StallM must stay low, W is sampled after the edge.
   task automatic op_a(input string tag, input logic rd, input logic wr, input logic [1:0] size,
                       input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic regw, input logic m2r, input logic [4:0] wreg);
      drive_a(rd, wr, size, sgn, addr, wdata, regw, m2r, wreg);
      #1;
      chk({tag, "_stall"}, 32'(a_stall), 32'd0);
      @(posedge clk);
      #1;
   endtask

   // One instruction on DUT b: count stalled cycles (bounded), check bubbles.
   task automatic op_b(input string tag, input logic rd, input logic wr, input logic [1:0] size,
                       input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic regw, input logic m2r, input logic [4:0] wreg,
                       input int exp_stalls);
      int n;
      n = 0;
      drive_b(rd, wr, size, sgn, addr, wdata, regw, m2r, wreg);
      #1;
      while (b_stall === 1'b1 && n < 10) begin
         n++;
         @(posedge clk);
         #1;
         chk({tag, "_bubble_regw"}, 32'(b_regw_w), 32'd0);
         chk({tag, "_bubble_m2r"}, 32'(b_m2r_w), 32'd0);
         chk({tag, "_bubble_aerr"}, 32'(b_aerr_w), 32'd0);
      end
      chk({tag, "_stall_cycles"}, 32'(n), 32'(exp_stalls));
      @(posedge clk);
      #1;
   endtask

   initial begin
      a_reset = 1'b1;
      b_reset = 1'b1;
      drive_a(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
      drive_b(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_a_regw", 32'(a_regw_w), 32'd0);
      chk("rst_a_m2r", 32'(a_m2r_w), 32'd0);
      chk("rst_a_rdata", a_rdata_w, 32'h0);
      chk("rst_a_alu", a_alu_w, 32'h0);
      chk("rst_a_wreg", 32'(a_wreg_w), 32'd0);
      chk("rst_a_aerr", 32'(a_aerr_w), 32'd0);
      chk("rst_a_stall", 32'(a_stall), 32'd0);
      chk("rst_b_regw", 32'(b_regw_w), 32'd0);
      chk("rst_b_stall", 32'(b_stall), 32'd0);
      a_reset = 1'b0;
      b_reset = 1'b0;

      // ---------------- WAIT_STATES = 0 ----------------
      op_a("st_w10", 1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 5'd0);
      chk("st_w10_regw", 32'(a_regw_w), 32'd0);
      chk("st_w10_aerr", 32'(a_aerr_w), 32'd0);
      op_a("ld_w10", 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 5'd5);
      chk("ld_w10_data", a_rdata_w, 32'hDEADBEEF);
      chk("ld_w10_m2r", 32'(a_m2r_w), 32'd1);
      chk("ld_w10_regw", 32'(a_regw_w), 32'd1);
      chk("ld_w10_wreg", 32'(a_wreg_w), 32'd5);
      chk("ld_w10_alu", a_alu_w, 32'h10);

      op_a("st_b13", 1'b0, 1'b1, 2'b00, 1'b0, 32'h13, 32'h12345680, 1'b0, 1'b0, 5'd0);
      op_a("ld_bs13", 1'b1, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b1, 1'b1, 5'd6);
      chk("ld_bs13_data", a_rdata_w, 32'hFFFFFF80);
      op_a("ld_bu13", 1'b1, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b1, 1'b1, 5'd6);
      chk("ld_bu13_data", a_rdata_w, 32'h00000080);
      op_a("ld_w10b", 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 5'd6);
      chk("ld_w10b_data", a_rdata_w, 32'h80ADBEEF);
      op_a("ld_bu11", 1'b1, 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 1'b1, 1'b1, 5'd6);
      chk("ld_bu11_data", a_rdata_w, 32'h000000BE);

      op_a("st_w14", 1'b0, 1'b1, 2'b10, 1'b0, 32'h14, 32'h0, 1'b0, 1'b0, 5'd0);
      op_a("st_h16", 1'b0, 1'b1, 2'b01, 1'b0, 32'h16, 32'hABCD1234, 1'b0, 1'b0, 5'd0);
      op_a("ld_w14", 1'b1, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 1'b1, 1'b1, 5'd7);
      chk("ld_w14_data", a_rdata_w, 32'h12340000);
      op_a("ld_hs16", 1'b1, 1'b0, 2'b01, 1'b1, 32'h16, 32'h0, 1'b1, 1'b1, 5'd7);
      chk("ld_hs16_data", a_rdata_w, 32'h00001234);
      op_a("ld_hs12", 1'b1, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b1, 1'b1, 5'd7);
      chk("ld_hs12_data", a_rdata_w, 32'hFFFF80AD);
      op_a("ld_hu12", 1'b1, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b1, 1'b1, 5'd7);
      chk("ld_hu12_data", a_rdata_w, 32'h000080AD);

      op_a("mis_w02", 1'b1, 1'b0, 2'b10, 1'b0, 32'h02, 32'h0, 1'b1, 1'b1, 5'd3);
      chk("mis_w02_aerr", 32'(a_aerr_w), 32'd1);
      chk("mis_w02_regw", 32'(a_regw_w), 32'd0);
      chk("mis_w02_m2r", 32'(a_m2r_w), 32'd0);
      chk("mis_w02_data", a_rdata_w, 32'h0);
      op_a("mis_sw12", 1'b0, 1'b1, 2'b10, 1'b0, 32'h12, 32'hFFFFFFFF, 1'b0, 1'b0, 5'd0);
      chk("mis_sw12_aerr", 32'(a_aerr_w), 32'd1);
      op_a("mis_h01", 1'b1, 1'b0, 2'b01, 1'b1, 32'h01, 32'h0, 1'b1, 1'b1, 5'd3);
      chk("mis_h01_aerr", 32'(a_aerr_w), 32'd1);
      chk("mis_h01_regw", 32'(a_regw_w), 32'd0);
      op_a("ld_w10c", 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 5'd8);
      chk("ld_w10c_data", a_rdata_w, 32'h80ADBEEF);
      chk("ld_w10c_aerr", 32'(a_aerr_w), 32'd0);

      op_a("st_wrap", 1'b0, 1'b1, 2'b10, 1'b0, 32'h1014, 32'hCAFEF00D, 1'b0, 1'b0, 5'd0);
      op_a("ld_w14b", 1'b1, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 1'b1, 1'b1, 5'd8);
      chk("ld_w14b_data", a_rdata_w, 32'hCAFEF00D);
      op_a("ld_wrap", 1'b1, 1'b0, 2'b10, 1'b0, 32'h1010, 32'h0, 1'b1, 1'b1, 5'd8);
      chk("ld_wrap_data", a_rdata_w, 32'h80ADBEEF);

      op_a("st_rw18", 1'b1, 1'b1, 2'b10, 1'b0, 32'h18, 32'h0BADF00D, 1'b0, 1'b0, 5'd0);
      op_a("ld_w18", 1'b1, 1'b0, 2'b10, 1'b0, 32'h18, 32'h0, 1'b1, 1'b1, 5'd9);
      chk("ld_w18_data", a_rdata_w, 32'h0BADF00D);

      op_a("alu_op", 1'b0, 1'b0, 2'b10, 1'b0, 32'h11112222, 32'h0, 1'b1, 1'b0, 5'd7);
      chk("alu_op_regw", 32'(a_regw_w), 32'd1);
      chk("alu_op_m2r", 32'(a_m2r_w), 32'd0);
      chk("alu_op_alu", a_alu_w, 32'h11112222);
      chk("alu_op_wreg", 32'(a_wreg_w), 32'd7);
      chk("alu_op_aerr", 32'(a_aerr_w), 32'd0);
      drive_a(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);

      // ---------------- WAIT_STATES = 3 ----------------
      op_b("b_st20", 1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, 1'b0, 1'b0, 5'd0, 3);
      chk("b_st20_aerr", 32'(b_aerr_w), 32'd0);
      op_b("b_ld20", 1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b1, 1'b1, 5'd9, 3);
      chk("b_ld20_data", b_rdata_w, 32'h11223344);
      chk("b_ld20_regw", 32'(b_regw_w), 32'd1);
      chk("b_ld20_m2r", 32'(b_m2r_w), 32'd1);
      chk("b_ld20_wreg", 32'(b_wreg_w), 32'd9);

      op_b("b_mis21", 1'b1, 1'b0, 2'b10, 1'b0, 32'h21, 32'h0, 1'b1, 1'b1, 5'd4, 0);
      chk("b_mis21_aerr", 32'(b_aerr_w), 32'd1);
      chk("b_mis21_regw", 32'(b_regw_w), 32'd0);
      op_b("b_alu", 1'b0, 1'b0, 2'b10, 1'b0, 32'h00ABCDEF, 32'h0, 1'b1, 1'b0, 5'd2, 0);
      chk("b_alu_regw", 32'(b_regw_w), 32'd1);
      chk("b_alu_alu", b_alu_w, 32'h00ABCDEF);

      // Reset in the k=2 cycle of a store: store must not commit.
      drive_b(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h55667788, 1'b0, 1'b0, 5'd1);
      #1;
      chk("b_rst_k0_stall", 32'(b_stall), 32'd1);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      chk("b_rst_k2_stall", 32'(b_stall), 32'd1);
      b_reset = 1'b1;
      @(posedge clk);
      #1;
      b_reset = 1'b0;
      drive_b(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
      #1;
      chk("b_rst_regw", 32'(b_regw_w), 32'd0);
      chk("b_rst_m2r", 32'(b_m2r_w), 32'd0);
      chk("b_rst_rdata", b_rdata_w, 32'h0);
      chk("b_rst_alu", b_alu_w, 32'h0);
      chk("b_rst_wreg", 32'(b_wreg_w), 32'd0);
      chk("b_rst_aerr", 32'(b_aerr_w), 32'd0);
      chk("b_rst_stall", 32'(b_stall), 32'd0);
      op_b("b_ld20b", 1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b1, 1'b1, 5'd9, 3);
      chk("b_ld20b_data", b_rdata_w, 32'h11223344);

      op_b("b_st_b21", 1'b0, 1'b1, 2'b00, 1'b0, 32'h21, 32'h000000AA, 1'b0, 1'b0, 5'd0, 3);
      op_b("b_ld_bs21", 1'b1, 1'b0, 2'b00, 1'b1, 32'h21, 32'h0, 1'b1, 1'b1, 5'd9, 3);
      chk("b_ld_bs21_data", b_rdata_w, 32'hFFFFFFAA);
      op_b("b_ld_w20c", 1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b1, 1'b1, 5'd9, 3);
      chk("b_ld_w20c_data", b_rdata_w, 32'h1122AA44);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
